// File: rtl/io_port_buffer_pkg.sv
// rtl/io_port_buffer_pkg.sv - shared limits and sizing rules for the I/O port buffer queues
package io_port_buffer_pkg;

    localparam int DEPTH_MIN = 4;

    function automatic int count_width(input int depth_width);
        return depth_width + 1;
    endfunction

    // Queue depth must be a power of two, at least DEPTH_MIN, with the reserve strictly inside it.
    function automatic bit depth_legal(input int depth, input int depth_width, input int reserve);
        return (depth >= DEPTH_MIN) && (depth == (1 << depth_width)) && (reserve < depth);
    endfunction

endpackage

// File: rtl/io_port_fifo.sv
// rtl/io_port_fifo.sv - single-clock FIFO with combinational head and occupancy count
module io_port_fifo
    import io_port_buffer_pkg::*;
#(
    parameter int WIDTH       = 36,
    parameter int DEPTH       = 8,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 push,
    input  logic [WIDTH-1:0]                     push_data,
    input  logic                                 pop,
    output logic [WIDTH-1:0]                     head_data,
    output logic [count_width(DEPTH_WIDTH)-1:0] count,
    output logic                                 full,
    output logic                                 empty
);

    localparam int CW = count_width(DEPTH_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]          count_q;
    logic                   do_push;
    logic                   do_pop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign count     = count_q;

    // Storage is deliberately not reset; the count alone defines what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/io_port_buffer.sv
// rtl/io_port_buffer.sv - read/write queue pair between external stream ports and the Datapath
module io_port_buffer
    import io_port_buffer_pkg::*;
#(
    parameter int WORD_WIDTH    = 36,
    parameter int DEPTH         = 8,
    parameter int DEPTH_WIDTH   = 3,
    parameter int WRITE_RESERVE = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  io_rden,
    output logic [WORD_WIDTH-1:0] io_read_data,
    output logic                  io_read_EF,
    input  logic                  io_wren,
    input  logic [WORD_WIDTH-1:0] io_write_data,
    output logic                  io_write_EF,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int CW = count_width(DEPTH_WIDTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] RESERVE_C = CW'(WRITE_RESERVE);

    logic [WORD_WIDTH-1:0] rd_head;
    logic [CW-1:0]         rd_count;
    logic                  rd_full;
    logic                  rd_empty;
    logic [CW-1:0]         wr_count;
    logic                  wr_full;
    logic                  wr_empty;
    logic [CW-1:0]         wr_count_next;
    logic                  wr_push_ok;
    logic                  wr_pop_ok;

    io_port_fifo #(
        .WIDTH       (WORD_WIDTH),
        .DEPTH       (DEPTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_read_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (io_rden),
        .head_data (rd_head),
        .count     (rd_count),
        .full      (rd_full),
        .empty     (rd_empty)
    );

    io_port_fifo #(
        .WIDTH       (WORD_WIDTH),
        .DEPTH       (DEPTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_write_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (io_wren),
        .push_data (io_write_data),
        .pop       (out_ready),
        .head_data (out_data),
        .count     (wr_count),
        .full      (wr_full),
        .empty     (wr_empty)
    );

    assign in_ready   = (rd_count < DEPTH_C);
    assign io_read_EF = (rd_count != '0);
    assign out_valid  = !wr_empty;

    assign wr_push_ok    = io_wren && !wr_full;
    assign wr_pop_ok     = out_ready && !wr_empty;
    assign wr_count_next = wr_count + CW'(wr_push_ok) - CW'(wr_pop_ok);

    // The write flag is registered from the next count so it lines up with the queue state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            io_read_data <= '0;
            overflow     <= 1'b0;
            io_write_EF  <= 1'b1;
        end else begin
            if (io_rden && !rd_empty) begin
                io_read_data <= rd_head;
            end
            if ((io_rden && rd_empty) || (io_wren && wr_full)) begin
                overflow <= 1'b1;
            end
            io_write_EF <= ((DEPTH_C - wr_count_next) > RESERVE_C);
        end
    end

    logic unused_ok;
    assign unused_ok = rd_full;

endmodule

// File: tb/tb_io_port_buffer.sv
// tb/tb_io_port_buffer.sv - scoreboard bench for io_port_buffer
module tb_io_port_buffer;

    localparam int W = 36;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          io_rden;
    logic [W-1:0]  io_read_data;
    logic          io_read_EF;
    logic          io_wren;
    logic [W-1:0]  io_write_data;
    logic          io_write_EF;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_rq [$];
    logic [W-1:0] exp_wq [$];
    logic         rd_pending = 1'b0;

    io_port_buffer #(
        .WORD_WIDTH    (36),
        .DEPTH         (8),
        .DEPTH_WIDTH   (3),
        .WRITE_RESERVE (6)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .io_rden       (io_rden),
        .io_read_data  (io_read_data),
        .io_read_EF    (io_read_EF),
        .io_wren       (io_wren),
        .io_write_data (io_write_data),
        .io_write_EF   (io_write_EF),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Monitor: read side compares one edge after a legal pop, write side on each handshake.
    always @(negedge clock) begin
        if (rd_pending) begin
            if (exp_rq.size() == 0) begin
                check("rd_unexpected_pop", io_read_data, '1);
            end else begin
                check("io_read_data", io_read_data, exp_rq.pop_front());
            end
        end
        rd_pending = reset_n && io_rden && io_read_EF;
        if (reset_n && out_valid && out_ready) begin
            if (exp_wq.size() == 0) begin
                check("wr_unexpected_out", out_data, '1);
            end else begin
                check("out_data", out_data, exp_wq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; io_rden = 1'b0;
        io_wren = 1'b0; io_write_data = '0; out_ready = 1'b0;
        do_reset();
        check("rst_in_ready", W'(in_ready), 1);
        check("rst_read_EF", W'(io_read_EF), 0);
        check("rst_write_EF", W'(io_write_EF), 1);
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_overflow", W'(overflow), 0);
        check("rst_read_data", io_read_data, 0);

        // Fill the read queue to capacity, then drain it in order.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = W'(i); exp_rq.push_back(W'(i));
            step();
        end
        in_valid = 1'b0;
        check("full_in_ready", W'(in_ready), 0);
        check("full_read_EF", W'(io_read_EF), 1);
        for (int i = 0; i < 8; i++) begin
            io_rden = 1'b1;
            step();
        end
        io_rden = 1'b0;
        step();
        check("drained_read_EF", W'(io_read_EF), 0);
        check("drained_in_ready", W'(in_ready), 1);

        // Write queue: reserve threshold, fill, overflow on the ninth write.
        for (int i = 0; i < 2; i++) begin
            io_wren = 1'b1; io_write_data = W'(36'hA0 + i); exp_wq.push_back(W'(36'hA0 + i));
            step();
        end
        io_wren = 1'b0;
        check("reserve_write_EF", W'(io_write_EF), 0);
        for (int i = 2; i < 8; i++) begin
            io_wren = 1'b1; io_write_data = W'(36'hA0 + i); exp_wq.push_back(W'(36'hA0 + i));
            step();
        end
        check("wfull_no_overflow", W'(overflow), 0);
        io_write_data = W'(36'hBAD);
        step();
        io_wren = 1'b0;
        check("wfull_overflow", W'(overflow), 1);
        check("wfull_head", out_data, W'(36'hA0));
        check("wfull_out_valid", W'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        out_ready = 1'b0;
        check("wdrain_out_valid", W'(out_valid), 0);
        check("wdrain_write_EF", W'(io_write_EF), 1);
        do_reset();
        check("rst2_overflow", W'(overflow), 0);

        // One word held, simultaneous push and pop.
        in_valid = 1'b1; in_data = W'(36'h11); exp_rq.push_back(W'(36'h11));
        step();
        in_data = W'(36'h22); io_rden = 1'b1; exp_rq.push_back(W'(36'h22));
        step();
        in_valid = 1'b0; io_rden = 1'b0;
        check("simul_read_EF", W'(io_read_EF), 1);
        check("simul_read_data", io_read_data, W'(36'h11));
        io_rden = 1'b1;
        step();
        io_rden = 1'b0;
        step();

        // Pop on empty: data holds, overflow sticks until reset.
        io_rden = 1'b1;
        step();
        io_rden = 1'b0;
        check("empty_pop_data", io_read_data, W'(36'h22));
        check("empty_pop_overflow", W'(overflow), 1);
        for (int i = 0; i < 4; i++) step();
        check("overflow_sticky", W'(overflow), 1);
        do_reset();
        check("rst3_overflow", W'(overflow), 0);

        // Streaming through the write queue past several pointer wraps.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            io_wren = 1'b1; io_write_data = W'(i); exp_wq.push_back(W'(i));
            step();
        end
        io_wren = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        check("stream_overflow", W'(overflow), 0);
        check("stream_wq_left", W'(exp_wq.size()), 0);
        check("stream_rq_left", W'(exp_rq.size()), 0);

        // Reset with five words queued on each side.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = W'(36'h50 + i);
            io_wren = 1'b1; io_write_data = W'(36'h60 + i);
            step();
        end
        in_valid = 1'b0; io_wren = 1'b0;
        check("pre_rst_out_valid", W'(out_valid), 1);
        check("pre_rst_read_EF", W'(io_read_EF), 1);
        reset_n = 1'b0;
        step();
        check("midrst_out_valid", W'(out_valid), 0);
        check("midrst_read_EF", W'(io_read_EF), 0);
        check("midrst_write_EF", W'(io_write_EF), 1);
        check("midrst_overflow", W'(overflow), 0);
        reset_n = 1'b1;
        step();
        check("post_rst_in_ready", W'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
